pe_array_feeder: RTL and testbench

// - Source end of the systolic PE array operand interface: reads K operand rows from the OPND1/OPND2 SRAMs,

---
 rtl/pe_array_pkg.sv | 22 ++
 rtl/skew_line.sv | 64 ++++++
 rtl/pe_array_feeder.sv | 223 ++++++++++++++++++++++
 tb/tb_pe_array_feeder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// ---------------------------------------------------------------------------
// pe_array_pkg
// Shared definitions for the PE array operand feeder:
//   - default array geometry and field widths
//   - feeder FSM state encoding
// ---------------------------------------------------------------------------
package pe_array_pkg;

    localparam int DEF_NUM_ROWS    = 32;
    localparam int DEF_NUM_COLS    = 32;
    localparam int DEF_OPND_BWIDTH = 8;
    localparam int DEF_K_BWIDTH    = 16;
    localparam int DEF_ADDR_BWIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/skew_line.sv
// ---------------------------------------------------------------------------
// skew_line
// DEPTH-stage shift register of {valid, data} used to skew one operand lane.
// DEPTH = 0 degenerates to a plain wire. All stages freeze while stall is
// high; rst clears every stage.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   stall    in   hold all stages for the cycle
//   data     in   WIDTH  {valid, payload} entering the line
//   delayed  out  WIDTH  {valid, payload} delayed by DEPTH cycles
//   pending  out  1      a valid bit will still be inside the line (or at its
//                        output) after the next unstalled edge
// ---------------------------------------------------------------------------
module skew_line #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed,
    output logic             pending
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_s;
            assign unused_s = clk ^ rst ^ stall;
            assign delayed  = data;
            // Nothing is held here; the upstream stage accounts for its own bit.
            assign pending  = 1'b0;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_r [DEPTH];

            // Shift register advancing one stage per unstalled cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        pipe_r[k] <= {WIDTH{1'b0}};
                    end
                end else if (!stall) begin
                    pipe_r[0] <= data;
                    for (int k = 1; k < DEPTH; k++) begin
                        pipe_r[k] <= pipe_r[k-1];
                    end
                end
            end

            // After the next shift the line holds the input plus all stages
            // but the last, so only those valid bits count as pending.
            always_comb begin
                pending = data[WIDTH-1];
                for (int k = 0; k < DEPTH - 1; k++) begin
                    pending = pending | pipe_r[k][WIDTH-1];
                end
            end

            assign delayed = pipe_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pe_array_feeder.sv
// ---------------------------------------------------------------------------
// pe_array_feeder
// Source end of the systolic PE array operand interface. One START reads
// K operand rows from the OPND1/OPND2 SRAMs, registers them (stage 0),
// skews lane i by i cycles and drives per-lane valids plus COMPUTE/FLUSH
// status, finishing with a one-cycle DONE pulse.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   STALL               freeze all state and outputs (read strobe forced low)
//   START               start a tile, sampled only in IDLE
//   K_LEN_in            reduction length (SRAM rows), latched at START
//   BASE_ADDR_in        first SRAM row, latched at START
//   SRAM_RD_EN_out      read strobe to both operand SRAMs
//   SRAM_RD_ADDR_out    read row address
//   OPND1/2_SRAM_in     SRAM read data, valid one cycle after the strobe
//   OPND1/2_DATA_out    skewed operand lanes to the array
//   OPND1/2_IS_VALID_out per-lane valid, skewed with the data
//   IS_COMPUTING_out    any output lane valid
//   IS_FLUSHING_out     NUM_ROWS cycles following the last valid lane
//   BUSY_out            FSM not idle
//   DONE_out            one-cycle pulse at end of the tile
// ---------------------------------------------------------------------------
module pe_array_feeder
    import pe_array_pkg::*;
#(
    parameter int NUM_ROWS    = DEF_NUM_ROWS,
    parameter int NUM_COLS    = DEF_NUM_COLS,
    parameter int OPND_BWIDTH = DEF_OPND_BWIDTH,
    parameter int K_BWIDTH    = DEF_K_BWIDTH,
    parameter int ADDR_BWIDTH = DEF_ADDR_BWIDTH
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            STALL,
    input  logic                            START,
    input  logic [K_BWIDTH-1:0]             K_LEN_in,
    input  logic [ADDR_BWIDTH-1:0]          BASE_ADDR_in,
    output logic                            SRAM_RD_EN_out,
    output logic [ADDR_BWIDTH-1:0]          SRAM_RD_ADDR_out,
    input  logic [NUM_ROWS*OPND_BWIDTH-1:0] OPND1_SRAM_in,
    input  logic [NUM_COLS*OPND_BWIDTH-1:0] OPND2_SRAM_in,
    output logic [NUM_ROWS*OPND_BWIDTH-1:0] OPND1_DATA_out,
    output logic [NUM_COLS*OPND_BWIDTH-1:0] OPND2_DATA_out,
    output logic [NUM_ROWS-1:0]             OPND1_IS_VALID_out,
    output logic [NUM_COLS-1:0]             OPND2_IS_VALID_out,
    output logic                            IS_COMPUTING_out,
    output logic                            IS_FLUSHING_out,
    output logic                            BUSY_out,
    output logic                            DONE_out
);

    localparam int                FCNT_W     = $clog2(NUM_ROWS + 1);
    localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(NUM_ROWS - 1);

    feeder_state_t              state_r, state_nx_s;
    logic                       rd_en_r, rd_en_nx_s;
    logic [ADDR_BWIDTH-1:0]     addr_r, addr_nx_s;
    logic [K_BWIDTH-1:0]        k_len_r, k_len_nx_s;
    logic [K_BWIDTH-1:0]        rd_cnt_r, rd_cnt_nx_s;
    logic [FCNT_W-1:0]          flush_cnt_r, flush_cnt_nx_s;
    logic                       is_flushing_r, is_flushing_nx_s;
    logic                       done_r, done_nx_s;
    logic                       busy_r;

    logic                            rd_pend_r;
    logic                            stage0_vld_r;
    logic [NUM_ROWS*OPND_BWIDTH-1:0] stage0_opnd1_r;
    logic [NUM_COLS*OPND_BWIDTH-1:0] stage0_opnd2_r;

    logic [NUM_ROWS-1:0] row_pending_s;
    logic [NUM_COLS-1:0] col_pending_s;
    logic                will_valid_s;

    // A valid bit survives the next edge if a read is issued or in flight,
    // or if any skew line still holds one short of its output.
    assign will_valid_s = rd_en_r | rd_pend_r | (|row_pending_s) | (|col_pending_s);

    // Next-state and next-output logic for the tile sequencer.
    always_comb begin
        state_nx_s       = state_r;
        rd_en_nx_s       = rd_en_r;
        addr_nx_s        = addr_r;
        k_len_nx_s       = k_len_r;
        rd_cnt_nx_s      = rd_cnt_r;
        flush_cnt_nx_s   = flush_cnt_r;
        is_flushing_nx_s = is_flushing_r;
        done_nx_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    if (K_LEN_in != {K_BWIDTH{1'b0}}) begin
                        state_nx_s  = ST_FEED;
                        rd_en_nx_s  = 1'b1;
                        addr_nx_s   = BASE_ADDR_in;
                        k_len_nx_s  = K_LEN_in;
                        rd_cnt_nx_s = {K_BWIDTH{1'b0}};
                    end else begin
                        done_nx_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                // rd_cnt_r counts reads already issued before this cycle.
                if (rd_cnt_r == k_len_r - K_BWIDTH'(1)) begin
                    state_nx_s = ST_DRAIN;
                    rd_en_nx_s = 1'b0;
                end else begin
                    rd_cnt_nx_s = rd_cnt_r + K_BWIDTH'(1);
                    addr_nx_s   = addr_r + ADDR_BWIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (!will_valid_s) begin
                    state_nx_s       = ST_FLUSH;
                    is_flushing_nx_s = 1'b1;
                    flush_cnt_nx_s   = {FCNT_W{1'b0}};
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) begin
                    state_nx_s       = ST_IDLE;
                    is_flushing_nx_s = 1'b0;
                    done_nx_s        = 1'b1;
                end else begin
                    flush_cnt_nx_s = flush_cnt_r + FCNT_W'(1);
                end
            end
            default: begin
                state_nx_s       = ST_IDLE;
                rd_en_nx_s       = 1'b0;
                is_flushing_nx_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, counters and registered control outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= ST_IDLE;
            rd_en_r       <= 1'b0;
            addr_r        <= {ADDR_BWIDTH{1'b0}};
            k_len_r       <= {K_BWIDTH{1'b0}};
            rd_cnt_r      <= {K_BWIDTH{1'b0}};
            flush_cnt_r   <= {FCNT_W{1'b0}};
            is_flushing_r <= 1'b0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else if (!STALL) begin
            state_r       <= state_nx_s;
            rd_en_r       <= rd_en_nx_s;
            addr_r        <= addr_nx_s;
            k_len_r       <= k_len_nx_s;
            rd_cnt_r      <= rd_cnt_nx_s;
            flush_cnt_r   <= flush_cnt_nx_s;
            is_flushing_r <= is_flushing_nx_s;
            done_r        <= done_nx_s;
            busy_r        <= (state_nx_s != ST_IDLE);
        end
    end

    // Stage-0 capture: SRAM data is valid the cycle after the strobe; the
    // SRAM holds its output across stalls, so capture simply waits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pend_r      <= 1'b0;
            stage0_vld_r   <= 1'b0;
            stage0_opnd1_r <= {(NUM_ROWS*OPND_BWIDTH){1'b0}};
            stage0_opnd2_r <= {(NUM_COLS*OPND_BWIDTH){1'b0}};
        end else if (!STALL) begin
            rd_pend_r    <= rd_en_r;
            stage0_vld_r <= rd_pend_r;
            if (rd_pend_r) begin
                stage0_opnd1_r <= OPND1_SRAM_in;
                stage0_opnd2_r <= OPND2_SRAM_in;
            end else begin
                stage0_opnd1_r <= {(NUM_ROWS*OPND_BWIDTH){1'b0}};
                stage0_opnd2_r <= {(NUM_COLS*OPND_BWIDTH){1'b0}};
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
            logic [OPND_BWIDTH:0] lane_s;
            skew_line #(.WIDTH(OPND_BWIDTH + 1), .DEPTH(i)) u_skew (
                .clk     (CLK),
                .rst     (RST),
                .stall   (STALL),
                .data    ({stage0_vld_r, stage0_opnd1_r[i*OPND_BWIDTH +: OPND_BWIDTH]}),
                .delayed (lane_s),
                .pending (row_pending_s[i])
            );
            assign OPND1_DATA_out[i*OPND_BWIDTH +: OPND_BWIDTH] = lane_s[OPND_BWIDTH-1:0];
            assign OPND1_IS_VALID_out[i]                        = lane_s[OPND_BWIDTH];
        end
        for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
            logic [OPND_BWIDTH:0] lane_s;
            skew_line #(.WIDTH(OPND_BWIDTH + 1), .DEPTH(j)) u_skew (
                .clk     (CLK),
                .rst     (RST),
                .stall   (STALL),
                .data    ({stage0_vld_r, stage0_opnd2_r[j*OPND_BWIDTH +: OPND_BWIDTH]}),
                .delayed (lane_s),
                .pending (col_pending_s[j])
            );
            assign OPND2_DATA_out[j*OPND_BWIDTH +: OPND_BWIDTH] = lane_s[OPND_BWIDTH-1:0];
            assign OPND2_IS_VALID_out[j]                        = lane_s[OPND_BWIDTH];
        end
    endgenerate

    // The strobe must drop immediately on STALL so the SRAM does not advance.
    assign SRAM_RD_EN_out   = rd_en_r & ~STALL;
    assign SRAM_RD_ADDR_out = addr_r;
    assign IS_COMPUTING_out = (|OPND1_IS_VALID_out) | (|OPND2_IS_VALID_out);
    assign IS_FLUSHING_out  = is_flushing_r;
    assign BUSY_out         = busy_r;
    assign DONE_out         = done_r;

endmodule

// File: tb/tb_pe_array_feeder.sv
// ---------------------------------------------------------------------------
// tb_pe_array_feeder
// Directed bench for pe_array_feeder with a 4x4 array and 8-bit lanes.
// SRAM row at address a: OPND1 lane i = {a[3:0], i+1}, OPND2 = OPND1 ^ 0x80.
// Cycle c counts from the cycle START is presented (c = 0).
// ---------------------------------------------------------------------------
module tb_pe_array_feeder;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int W  = 8;
    localparam int KB = 16;
    localparam int AB = 10;

    logic            CLK = 1'b0;
    logic            RST;
    logic            STALL;
    logic            START;
    logic [KB-1:0]   K_LEN_in;
    logic [AB-1:0]   BASE_ADDR_in;
    logic            SRAM_RD_EN_out;
    logic [AB-1:0]   SRAM_RD_ADDR_out;
    logic [NR*W-1:0] OPND1_SRAM_in = '0;
    logic [NC*W-1:0] OPND2_SRAM_in = '0;
    logic [NR*W-1:0] OPND1_DATA_out;
    logic [NC*W-1:0] OPND2_DATA_out;
    logic [NR-1:0]   OPND1_IS_VALID_out;
    logic [NC-1:0]   OPND2_IS_VALID_out;
    logic            IS_COMPUTING_out;
    logic            IS_FLUSHING_out;
    logic            BUSY_out;
    logic            DONE_out;

    int n_vec = 0;
    int n_err = 0;

    pe_array_feeder #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .OPND_BWIDTH(W), .K_BWIDTH(KB), .ADDR_BWIDTH(AB)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .STALL              (STALL),
        .START              (START),
        .K_LEN_in           (K_LEN_in),
        .BASE_ADDR_in       (BASE_ADDR_in),
        .SRAM_RD_EN_out     (SRAM_RD_EN_out),
        .SRAM_RD_ADDR_out   (SRAM_RD_ADDR_out),
        .OPND1_SRAM_in      (OPND1_SRAM_in),
        .OPND2_SRAM_in      (OPND2_SRAM_in),
        .OPND1_DATA_out     (OPND1_DATA_out),
        .OPND2_DATA_out     (OPND2_DATA_out),
        .OPND1_IS_VALID_out (OPND1_IS_VALID_out),
        .OPND2_IS_VALID_out (OPND2_IS_VALID_out),
        .IS_COMPUTING_out   (IS_COMPUTING_out),
        .IS_FLUSHING_out    (IS_FLUSHING_out),
        .BUSY_out           (BUSY_out),
        .DONE_out           (DONE_out)
    );

    always #5 CLK = ~CLK;

    function automatic logic [NR*W-1:0] row1(input logic [AB-1:0] a);
        logic [NR*W-1:0] r;
        for (int i = 0; i < NR; i++) begin
            r[i*W +: W] = {a[3:0], 4'(i + 1)};
        end
        return r;
    endfunction

    // Operand SRAM: data appears the cycle after the strobe and is held otherwise.
    always @(posedge CLK) begin
        if (SRAM_RD_EN_out) begin
            OPND1_SRAM_in <= row1(SRAM_RD_ADDR_out);
            OPND2_SRAM_in <= row1(SRAM_RD_ADDR_out) ^ 32'h80808080;
        end
    end

    task automatic step();
        @(posedge CLK);
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int n_done;
    int done_cyc;
    int n_rd;
    int n_fl;
    int first_fl;
    int last_v3;
    int n_busy;

    initial begin
        RST = 1'b1; STALL = 1'b0; START = 1'b0; K_LEN_in = '0; BASE_ADDR_in = '0;
        step(); step();
        chk("rst_busy",   32'(BUSY_out), 32'd0);
        chk("rst_done",   32'(DONE_out), 32'd0);
        chk("rst_rden",   32'(SRAM_RD_EN_out), 32'd0);
        chk("rst_valid1", 32'(OPND1_IS_VALID_out), 32'd0);
        chk("rst_data1",  OPND1_DATA_out, 32'd0);
        chk("rst_flush",  32'(IS_FLUSHING_out), 32'd0);
        RST = 1'b0;
        step();

        // ---- K=3, BASE=5; inputs changed after START must be ignored ----
        START = 1'b1; K_LEN_in = 16'd3; BASE_ADDR_in = 10'd5;
        step();                                         // c1
        START = 1'b0; K_LEN_in = 16'd9; BASE_ADDR_in = 10'd100;
        chk("t1_c1_rden", 32'(SRAM_RD_EN_out), 32'd1);
        chk("t1_c1_addr", 32'(SRAM_RD_ADDR_out), 32'd5);
        chk("t1_c1_busy", 32'(BUSY_out), 32'd1);
        step();                                         // c2
        chk("t1_c2_addr", 32'(SRAM_RD_ADDR_out), 32'd6);
        chk("t1_c2_valid", 32'(OPND1_IS_VALID_out), 32'd0);
        step();                                         // c3
        chk("t1_c3_addr", 32'(SRAM_RD_ADDR_out), 32'd7);
        chk("t1_c3_data1", OPND1_DATA_out, 32'h00000051);
        chk("t1_c3_valid1", 32'(OPND1_IS_VALID_out), 32'h1);
        chk("t1_c3_comp", 32'(IS_COMPUTING_out), 32'd1);
        step();                                         // c4
        chk("t1_c4_rden", 32'(SRAM_RD_EN_out), 32'd0);
        chk("t1_c4_data1", OPND1_DATA_out, 32'h00005261);
        chk("t1_c4_valid1", 32'(OPND1_IS_VALID_out), 32'h3);
        step();                                         // c5
        chk("t1_c5_data1", OPND1_DATA_out, 32'h00536271);
        chk("t1_c5_data2", OPND2_DATA_out, 32'h00D3E2F1);
        chk("t1_c5_valid2", 32'(OPND2_IS_VALID_out), 32'h7);
        step();                                         // c6
        chk("t1_c6_data1", OPND1_DATA_out, 32'h54637200);
        chk("t1_c6_valid1", 32'(OPND1_IS_VALID_out), 32'hE);
        step(); step();                                 // c8
        chk("t1_c8_data1", OPND1_DATA_out, 32'h74000000);
        chk("t1_c8_valid1", 32'(OPND1_IS_VALID_out), 32'h8);
        chk("t1_c8_comp", 32'(IS_COMPUTING_out), 32'd1);
        chk("t1_c8_flush", 32'(IS_FLUSHING_out), 32'd0);
        step();                                         // c9
        chk("t1_c9_comp", 32'(IS_COMPUTING_out), 32'd0);
        chk("t1_c9_flush", 32'(IS_FLUSHING_out), 32'd1);
        chk("t1_c9_data1", OPND1_DATA_out, 32'd0);
        step(); step(); step();                         // c12
        chk("t1_c12_flush", 32'(IS_FLUSHING_out), 32'd1);
        chk("t1_c12_done", 32'(DONE_out), 32'd0);
        chk("t1_c12_busy", 32'(BUSY_out), 32'd1);
        step();                                         // c13
        chk("t1_c13_done", 32'(DONE_out), 32'd1);
        chk("t1_c13_flush", 32'(IS_FLUSHING_out), 32'd0);
        chk("t1_c13_busy", 32'(BUSY_out), 32'd0);
        step();                                         // c14

        chk("t1_c14_done", 32'(DONE_out), 32'd0);

        // ---- K=0: immediate DONE, never busy ----
        START = 1'b1; K_LEN_in = 16'd0;
        step();
        START = 1'b0;
        chk("t2_done", 32'(DONE_out), 32'd1);
        chk("t2_busy", 32'(BUSY_out), 32'd0);
        chk("t2_rden", 32'(SRAM_RD_EN_out), 32'd0);
        step();
        chk("t2_done_off", 32'(DONE_out), 32'd0);
        chk("t2_busy_off", 32'(BUSY_out), 32'd0);
        chk("t2_valid", 32'(OPND1_IS_VALID_out), 32'd0);

        // ---- K=4, BASE=20, STALL during c3..c5 ----
        START = 1'b1; K_LEN_in = 16'd4; BASE_ADDR_in = 10'd20;
        step();                                         // c1
        START = 1'b0;
        chk("t3_c1_addr", 32'(SRAM_RD_ADDR_out), 32'd20);
        step();                                         // c2
        chk("t3_c2_addr", 32'(SRAM_RD_ADDR_out), 32'd21);
        for (int c = 3; c <= 5; c++) begin
            step();
            STALL = 1'b1;
            #1;
            chk("t3_stall_rden", 32'(SRAM_RD_EN_out), 32'd0);
            chk("t3_stall_addr", 32'(SRAM_RD_ADDR_out), 32'd22);
            chk("t3_stall_data1", OPND1_DATA_out, 32'h00000041);
            chk("t3_stall_valid1", 32'(OPND1_IS_VALID_out), 32'h1);
        end
        step();                                         // c6
        STALL = 1'b0;
        #1;
        chk("t3_c6_rden", 32'(SRAM_RD_EN_out), 32'd1);
        chk("t3_c6_addr", 32'(SRAM_RD_ADDR_out), 32'd22);
        step();                                         // c7
        chk("t3_c7_addr", 32'(SRAM_RD_ADDR_out), 32'd23);
        chk("t3_c7_data1", OPND1_DATA_out, 32'h00004251);
        step();                                         // c8
        chk("t3_c8_rden", 32'(SRAM_RD_EN_out), 32'd0);
        repeat (8) step();                              // c16
        chk("t3_c16_done", 32'(DONE_out), 32'd0);
        step();                                         // c17
        chk("t3_c17_done", 32'(DONE_out), 32'd1);

        // ---- address wrap: BASE=1022, K=4 ----
        START = 1'b1; K_LEN_in = 16'd4; BASE_ADDR_in = 10'd1022;
        step();                                         // c1
        START = 1'b0;
        chk("t4_c1_addr", 32'(SRAM_RD_ADDR_out), 32'd1022);
        step();
        chk("t4_c2_addr", 32'(SRAM_RD_ADDR_out), 32'd1023);
        step();
        chk("t4_c3_addr", 32'(SRAM_RD_ADDR_out), 32'd0);
        chk("t4_c3_data1", OPND1_DATA_out, 32'h000000E1);
        step();
        chk("t4_c4_addr", 32'(SRAM_RD_ADDR_out), 32'd1);
        chk("t4_c4_data1", OPND1_DATA_out, 32'h0000E2F1);
        step();
        chk("t4_c5_rden", 32'(SRAM_RD_EN_out), 32'd0);
        repeat (8) step();                              // c13
        chk("t4_c13_done", 32'(DONE_out), 32'd0);
        step();                                         // c14
        chk("t4_c14_done", 32'(DONE_out), 32'd1);

        // ---- K=2, START re-pulsed in DRAIN is ignored ----
        START = 1'b1; K_LEN_in = 16'd2; BASE_ADDR_in = 10'd0;
        step();                                         // c1
        START = 1'b0;
        chk("t5_c1_addr", 32'(SRAM_RD_ADDR_out), 32'd0);
        step();
        chk("t5_c2_addr", 32'(SRAM_RD_ADDR_out), 32'd1);
        step();                                         // c3, DRAIN
        chk("t5_c3_rden", 32'(SRAM_RD_EN_out), 32'd0);
        chk("t5_c3_busy", 32'(BUSY_out), 32'd1);
        START = 1'b1; K_LEN_in = 16'd5;
        step();                                         // c4
        START = 1'b0;
        n_done = 0; done_cyc = -1; n_rd = 0; n_fl = 0; first_fl = -1; last_v3 = -1;
        for (int c = 4; c <= 20; c++) begin
            if (DONE_out) begin n_done++; done_cyc = c; end
            if (SRAM_RD_EN_out) n_rd++;
            if (IS_FLUSHING_out) begin
                n_fl++;
                if (first_fl < 0) first_fl = c;
            end
            if (OPND1_IS_VALID_out[3]) last_v3 = c;
            step();
        end
        chk("t5_done_count", 32'(n_done), 32'd1);
        chk("t5_done_cycle", 32'(done_cyc), 32'd12);
        chk("t5_extra_reads", 32'(n_rd), 32'd0);
        chk("t5_lane3_last", 32'(last_v3), 32'd7);
        chk("t5_flush_len", 32'(n_fl), 32'd4);
        chk("t5_flush_first", 32'(first_fl), 32'd8);

        // ---- RST (with STALL) in FEED aborts the tile ----
        START = 1'b1; K_LEN_in = 16'd4; BASE_ADDR_in = 10'd8;
        step();                                         // c1
        START = 1'b0;
        step();                                         // c2
        RST = 1'b1; STALL = 1'b1;
        step();                                         // c3
        RST = 1'b0; STALL = 1'b0;
        #1;
        chk("t6_rden",   32'(SRAM_RD_EN_out), 32'd0);
        chk("t6_addr",   32'(SRAM_RD_ADDR_out), 32'd0);
        chk("t6_busy",   32'(BUSY_out), 32'd0);
        chk("t6_valid1", 32'(OPND1_IS_VALID_out), 32'd0);
        chk("t6_valid2", 32'(OPND2_IS_VALID_out), 32'd0);
        chk("t6_data1",  OPND1_DATA_out, 32'd0);
        chk("t6_data2",  OPND2_DATA_out, 32'd0);
        chk("t6_comp",   32'(IS_COMPUTING_out), 32'd0);
        chk("t6_flush",  32'(IS_FLUSHING_out), 32'd0);
        chk("t6_done",   32'(DONE_out), 32'd0);
        n_done = 0; n_rd = 0; n_busy = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (DONE_out) n_done++;
            if (SRAM_RD_EN_out) n_rd++;
            if (BUSY_out) n_busy++;
        end
        chk("t6_no_done", 32'(n_done), 32'd0);
        chk("t6_no_reads", 32'(n_rd), 32'd0);
        chk("t6_no_busy", 32'(n_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
